// File: rtl/ahb_lite_sram_initiator.sv
// AHB-Lite initiator: turns a valid/ready command stream into single NONSEQ transfers,
// with overlapped address (A) and data (D) phases and in-order responses.
module ahb_lite_sram_initiator #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [2:0]    cmd_size,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          busy,
   output logic [AW-1:0] HADDR,
   output logic          HWRITE,
   output logic [2:0]    HSIZE,
   output logic [1:0]    HTRANS,
   output logic [DW-1:0] HWDATA,
   input  logic [DW-1:0] HRDATA,
   input  logic          HREADY,
   input  logic          HRESP
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_DATA,
      ST_DATA,
      ST_ERR_CANCEL
   } state_t;

   logic          a_valid;
   logic          a_write;
   logic [AW-1:0] a_addr;
   logic [2:0]    a_size;
   logic [DW-1:0] a_wdata;
   logic          d_valid;
   logic          d_write;
   logic [DW-1:0] d_wdata;
   logic          cancel;
   logic          cmd_fire;
   state_t        state;

   // No new command while stalled, during the cancelled slot, or in the first ERROR cycle
   assign cmd_ready = (~a_valid | HREADY) & ~cancel & ~(HRESP & ~HREADY);
   assign cmd_fire  = cmd_valid & cmd_ready;

   assign HTRANS = (a_valid & ~cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HADDR  = a_addr;
   assign HSIZE  = a_size;
   assign HWRITE = a_write;
   assign HWDATA = d_wdata;

   always_comb begin
      state = ST_IDLE;
      if (cancel)
         state = ST_ERR_CANCEL;
      else if (a_valid && d_valid)
         state = ST_ADDR_DATA;
      else if (a_valid)
         state = ST_ADDR;
      else if (d_valid)
         state = ST_DATA;
   end

   assign busy = (state != ST_IDLE);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         a_valid   <= 1'b0;
         a_write   <= 1'b0;
         a_addr    <= '0;
         a_size    <= '0;
         a_wdata   <= '0;
         d_valid   <= 1'b0;
         d_write   <= 1'b0;
         d_wdata   <= '0;
         cancel    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else if (HREADY) begin
         rsp_valid <= d_valid;
         if (d_valid) begin
            rsp_err   <= HRESP;
            rsp_rdata <= d_write ? '0 : HRDATA;
         end
         if (cancel) begin
            // The A-stage command was never on the bus; keep it and re-issue next cycle
            d_valid <= 1'b0;
            cancel  <= 1'b0;
         end else begin
            d_valid <= a_valid;
            d_write <= a_write;
            d_wdata <= a_wdata;
            a_valid <= cmd_fire;
            if (cmd_fire) begin
               a_write <= cmd_write;
               a_addr  <= cmd_addr;
               a_size  <= cmd_size;
               a_wdata <= cmd_wdata;
            end else begin
               a_write <= 1'b0;
               a_addr  <= '0;
               a_size  <= '0;
               a_wdata <= '0;
            end
         end
      end else begin
         rsp_valid <= 1'b0;
         if (HRESP && a_valid && !cancel)
            cancel <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ahb_lite_sram_initiator.sv
// Directed bench for ahb_lite_sram_initiator against a small AHB responder model
// with programmable wait states and two-cycle ERROR responses.
module tb_ahb_lite_sram_initiator;

   logic        HCLK;
   logic        HRESETn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_size;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   ahb_lite_sram_initiator #(.AW(32), .DW(32)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
      .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   int cyc = 0;
   always @(posedge HCLK) cyc <= cyc + 1;

   // Responder model: memory preset to 0xA0000000 + word index
   logic [31:0] mem [0:255];
   logic        dp_valid;
   logic        dp_write;
   logic [31:0] dp_addr;
   logic [3:0]  dcyc;
   logic [31:0] err_addr;
   logic [31:0] stall_addr;
   logic [3:0]  stall_n;

   always_comb begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      if (dp_valid && dp_addr == err_addr) begin
         HRESP  = 1'b1;
         HREADY = (dcyc == 4'd1);
      end else if (dp_valid && dp_addr == stall_addr) begin
         HREADY = (dcyc == stall_n);
      end
   end

   assign HRDATA = (dp_valid && !dp_write) ? mem[dp_addr[9:2]] : 32'hDEAD_BEEF;

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_addr  <= 32'h0;
         dcyc     <= 4'd0;
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      end else if (HREADY) begin
         if (dp_valid && dp_write && !HRESP) mem[dp_addr[9:2]] <= HWDATA;
         dp_valid <= (HTRANS == 2'b10);
         dp_addr  <= HADDR;
         dp_write <= HWRITE;
         dcyc     <= 4'd0;
      end else begin
         dcyc <= dcyc + 4'd1;
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } rsp_t;
   rsp_t rq[$];

   always @(negedge HCLK) if (rsp_valid) rq.push_back('{rsp_rdata, rsp_err, cyc});

   typedef struct {
      logic        w;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;
   vec_t tv[9];

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_cmd(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_size  = s;
      cmd_wdata = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k0;
      HRESETn    = 1'b0;
      cmd_valid  = 1'b0;
      cmd_write  = 1'b0;
      cmd_addr   = 32'h0;
      cmd_size   = 3'd0;
      cmd_wdata  = 32'h0;
      err_addr   = 32'hFFFF_FFFF;
      stall_addr = 32'hFFFF_FFFF;
      stall_n    = 4'd0;
      tv[0] = '{1'b1, 32'h10, 3'd2, 32'h1234_5678, 32'h0,         1'b0};
      tv[1] = '{1'b0, 32'h10, 3'd2, 32'h0,         32'h1234_5678, 1'b0};
      tv[2] = '{1'b0, 32'h00, 3'd2, 32'h0,         32'hA000_0000, 1'b0};
      tv[3] = '{1'b0, 32'h04, 3'd2, 32'h0,         32'hA000_0001, 1'b0};
      tv[4] = '{1'b0, 32'h08, 3'd2, 32'h0,         32'hA000_0002, 1'b0};
      tv[5] = '{1'b0, 32'h0C, 3'd2, 32'h0,         32'hA000_0003, 1'b0};
      tv[6] = '{1'b1, 32'h14, 3'd2, 32'hCAFE_F00D, 32'h0,         1'b0};
      tv[7] = '{1'b1, 32'h03, 3'd0, 32'h0000_00AB, 32'h0,         1'b0};
      tv[8] = '{1'b0, 32'h14, 3'd2, 32'h0,         32'hCAFE_F00D, 1'b0};

      @(negedge HCLK);
      @(negedge HCLK);
      chk("rst_htrans", 32'(HTRANS), 32'd0);
      chk("rst_haddr", HADDR, 32'h0);
      chk("rst_hwdata", HWDATA, 32'h0);
      chk("rst_hsize", 32'(HSIZE), 32'd0);
      chk("rst_hwrite", 32'(HWRITE), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      HRESETn = 1'b1;
      @(negedge HCLK);

      // Table: back-to-back commands, zero wait states
      k0 = cyc;
      for (int i = 0; i < 9; i++) begin
         set_cmd(tv[i].w, tv[i].addr, tv[i].size, tv[i].wdata);
         #1;
         chk($sformatf("tbl%0d_cmd_ready", i), 32'(cmd_ready), 32'd1);
         @(negedge HCLK);
         chk($sformatf("tbl%0d_htrans", i), 32'(HTRANS), 32'h2);
         chk($sformatf("tbl%0d_haddr", i), HADDR, tv[i].addr);
         chk($sformatf("tbl%0d_hsize", i), 32'(HSIZE), 32'(tv[i].size));
         chk($sformatf("tbl%0d_hwrite", i), 32'(HWRITE), 32'(tv[i].w));
         if (i > 0 && tv[i-1].w) chk($sformatf("tbl%0d_hwdata", i), HWDATA, tv[i-1].wdata);
      end
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) @(negedge HCLK);
      chk("tbl_rsp_count", 32'(rq.size()), 32'd9);
      for (int i = 0; i < 9; i++) begin
         if (i < rq.size()) begin
            chk($sformatf("tbl%0d_rdata", i), rq[i].rdata, tv[i].exp_rdata);
            chk($sformatf("tbl%0d_err", i), 32'(rq[i].err), 32'(tv[i].exp_err));
            chk($sformatf("tbl%0d_rsp_cycle", i), 32'(rq[i].cyc), 32'(k0 + 3 + i));
         end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL tbl%0d_rsp: got none expected response", i);
         end
      end
      chk("tbl_idle_htrans", 32'(HTRANS), 32'd0);
      chk("tbl_idle_busy", 32'(busy), 32'd0);

      // Three wait states on read 0x20 with 0x24 in the address phase
      stall_addr = 32'h20;
      stall_n    = 4'd3;
      k0 = cyc;
      set_cmd(1'b0, 32'h20, 3'd2, 32'h0);
      @(negedge HCLK);
      set_cmd(1'b0, 32'h24, 3'd2, 32'h0);
      @(negedge HCLK);
      set_cmd(1'b0, 32'h28, 3'd2, 32'h0);
      for (int w = 0; w < 3; w++) begin
         #1;
         chk($sformatf("ws%0d_haddr", w), HADDR, 32'h24);
         chk($sformatf("ws%0d_htrans", w), 32'(HTRANS), 32'h2);
         chk($sformatf("ws%0d_cmd_ready", w), 32'(cmd_ready), 32'd0);
         chk($sformatf("ws%0d_rsp_valid", w), 32'(rsp_valid), 32'd0);
         @(negedge HCLK);
      end
      #1;
      chk("ws_end_cmd_ready", 32'(cmd_ready), 32'd1);
      @(negedge HCLK);
      cmd_valid = 1'b0;
      chk("ws_rsp_cycle", 32'(cyc), 32'(k0 + 6));
      chk("ws_rsp0_valid", 32'(rsp_valid), 32'd1);
      chk("ws_rsp0_rdata", rsp_rdata, 32'hA000_0008);
      @(negedge HCLK);
      chk("ws_rsp1_valid", 32'(rsp_valid), 32'd1);
      chk("ws_rsp1_rdata", rsp_rdata, 32'hA000_0009);
      @(negedge HCLK);
      chk("ws_rsp2_valid", 32'(rsp_valid), 32'd1);
      chk("ws_rsp2_rdata", rsp_rdata, 32'hA000_000A);
      stall_addr = 32'hFFFF_FFFF;
      @(negedge HCLK);

      // Two-cycle ERROR on write 0x40 with read 0x44 pending
      err_addr = 32'h40;
      rq.delete();
      set_cmd(1'b1, 32'h40, 3'd2, 32'h55AA_55AA);
      @(negedge HCLK);
      set_cmd(1'b0, 32'h44, 3'd2, 32'h0);
      @(negedge HCLK);
      cmd_valid = 1'b0;
      chk("err1_htrans", 32'(HTRANS), 32'h2);
      chk("err1_haddr", HADDR, 32'h44);
      chk("err1_hwdata", HWDATA, 32'h55AA_55AA);
      #1;
      chk("err1_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge HCLK);
      chk("err2_htrans_idle", 32'(HTRANS), 32'd0);
      chk("err2_busy", 32'(busy), 32'd1);
      chk("err2_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge HCLK);
      chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("err_rsp_err", 32'(rsp_err), 32'd1);
      chk("err_rsp_rdata", rsp_rdata, 32'h0);
      chk("reissue_htrans", 32'(HTRANS), 32'h2);
      chk("reissue_haddr", HADDR, 32'h44);
      chk("reissue_hwrite", 32'(HWRITE), 32'd0);
      @(negedge HCLK);
      chk("reissue_gap_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge HCLK);
      chk("reissue_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("reissue_rsp_err", 32'(rsp_err), 32'd0);
      chk("reissue_rsp_rdata", rsp_rdata, 32'hA000_0011);
      err_addr = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) @(negedge HCLK);
      chk("err_rsp_count", 32'(rq.size()), 32'd2);
      chk("err_idle_busy", 32'(busy), 32'd0);

      // Asynchronous reset while in ADDR_DATA
      set_cmd(1'b0, 32'h08, 3'd2, 32'h0);
      @(negedge HCLK);
      set_cmd(1'b0, 32'h0C, 3'd2, 32'h0);
      @(negedge HCLK);
      cmd_valid = 1'b0;
      chk("ar_pre_busy", 32'(busy), 32'd1);
      chk("ar_pre_htrans", 32'(HTRANS), 32'h2);
      #2;
      rq.delete();
      HRESETn = 1'b0;
      #1;
      chk("ar_htrans", 32'(HTRANS), 32'd0);
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_haddr", HADDR, 32'h0);
      @(negedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      for (int i = 0; i < 3; i++) @(negedge HCLK);
      chk("ar_no_rsp", 32'(rq.size()), 32'd0);
      set_cmd(1'b0, 32'h08, 3'd2, 32'h0);
      #1;
      chk("ar_post_cmd_ready", 32'(cmd_ready), 32'd1);
      @(negedge HCLK);
      cmd_valid = 1'b0;
      chk("ar_post_htrans", 32'(HTRANS), 32'h2);
      chk("ar_post_haddr", HADDR, 32'h08);
      @(negedge HCLK);
      @(negedge HCLK);
      chk("ar_post_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("ar_post_rsp_rdata", rsp_rdata, 32'hA000_0002);
      chk("ar_post_rsp_err", 32'(rsp_err), 32'd0);
      @(negedge HCLK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
